// File: rtl/fifo_serializer.sv
// Show-ahead FIFO drain that splits each DataWidth word into OutWidth beats,
// least-significant beat first, on a valid/ready stream.
module fifo_serializer #(
    parameter int DataWidth = 32,
    parameter int OutWidth  = 8
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 flush,
    input  logic                 fifoEmpty,
    input  logic [DataWidth-1:0] fifoData,
    output logic                 fifoReadEn,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [OutWidth-1:0]  outData,
    output logic                 outLast,
    output logic                 busy
);
    localparam int Beats     = DataWidth / OutWidth;
    localparam int BeatWidth = (Beats > 1) ? $clog2(Beats) : 1;
    localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(Beats - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                 state_reg, state_next;
    logic [DataWidth-1:0]   word_reg, word_next;
    logic [BeatWidth-1:0]   beat_reg, beat_next;
    logic [OutWidth-1:0]    beat_slices [Beats];
    logic                   fire;
    logic                   last_beat;

    genvar gi;
    generate
        for (gi = 0; gi < Beats; gi++) begin : g_slice
            assign beat_slices[gi] = word_reg[gi*OutWidth +: OutWidth];
        end
    endgenerate

    assign outValid  = (state_reg == SEND);
    assign busy      = outValid;
    assign last_beat = outValid && (beat_reg == LastBeat);
    assign outLast   = last_beat;
    assign outData   = beat_slices[beat_reg];
    assign fire      = outValid && outReady;

    // Popping on the last-beat fire keeps the stream gap-free across words.
    assign fifoReadEn = !flush && !fifoEmpty && ((state_reg == IDLE) || (fire && last_beat));

    always_comb begin
        state_next = state_reg;
        word_next  = word_reg;
        beat_next  = beat_reg;
        if (flush) begin
            state_next = IDLE;
            beat_next  = '0;
        end else if (fifoReadEn) begin
            state_next = SEND;
            word_next  = fifoData;
            beat_next  = '0;
        end else if (fire && !last_beat) begin
            beat_next = beat_reg + 1'b1;
        end else if (fire && last_beat) begin
            state_next = IDLE;
            beat_next  = '0;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_reg <= IDLE;
            word_reg  <= '0;
            beat_reg  <= '0;
        end else begin
            state_reg <= state_next;
            word_reg  <= word_next;
            beat_reg  <= beat_next;
        end
    end
endmodule

// File: tb/tb_fifo_serializer.sv
// Scoreboard bench: stimulus models the FIFO and queues expected beats;
// a negedge monitor compares every accepted beat and the flagged checks.
module tb_fifo_serializer;
    logic        clk = 1'b0;
    logic        rstN;
    logic        flush;
    logic        fifoEmpty;
    logic [31:0] fifoData;
    logic        fifoReadEn;
    logic        outValid;
    logic        outReady;
    logic [7:0]  outData;
    logic        outLast;
    logic        busy;

    always #5 clk = ~clk;

    fifo_serializer #(.DataWidth(32), .OutWidth(8)) dut (
        .clk        (clk),
        .rstN       (rstN),
        .flush      (flush),
        .fifoEmpty  (fifoEmpty),
        .fifoData   (fifoData),
        .fifoReadEn (fifoReadEn),
        .outValid   (outValid),
        .outReady   (outReady),
        .outData    (outData),
        .outLast    (outLast),
        .busy       (busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       pop;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] fifo_q [$];
    int          rd_idx = 0;
    int          vectors = 0;
    int          miscompares = 0;

    logic chk_reset = 1'b0;
    logic chk_nv    = 1'b0;
    logic chk_v     = 1'b0;
    logic chk_pop   = 1'b0;
    logic chk_nopop = 1'b0;
    logic tmo_flag  = 1'b0;

    // ---------------- monitor ----------------
    logic       stall_seen = 1'b0;
    logic [7:0] stall_data = '0;
    logic       stall_last = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
        else
            $display("ok   %s: %0h", name, act);
    endtask

    always @(negedge clk) begin
        if (fifoEmpty)
            check("readen_while_empty", 32'(fifoReadEn), 32'd0);
        if (chk_reset) begin
            check("rst_outValid", 32'(outValid), 32'd0);
            check("rst_outData", 32'(outData), 32'd0);
            check("rst_outLast", 32'(outLast), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_fifoReadEn", 32'(fifoReadEn), 32'd0);
        end
        if (chk_nv)    check("outValid_low", 32'(outValid), 32'd0);
        if (chk_v)     check("outValid_high", 32'(outValid), 32'd1);
        if (chk_pop)   check("pop_expected", 32'(fifoReadEn), 32'd1);
        if (chk_nopop) check("pop_forbidden", 32'(fifoReadEn), 32'd0);
        if (stall_seen && rstN) begin
            check("stall_valid", 32'(outValid), 32'd1);
            check("stall_data", 32'(outData), 32'(stall_data));
            check("stall_last", 32'(outLast), 32'(stall_last));
        end
        if (outValid && outReady) begin
            if (rd_idx < exp_q.size()) begin
                check("beat_data", 32'(outData), 32'(exp_q[rd_idx].data));
                check("beat_last", 32'(outLast), 32'(exp_q[rd_idx].last));
                check("beat_pop", 32'(fifoReadEn), 32'(exp_q[rd_idx].pop));
                rd_idx++;
            end else begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_beat: got %0h want none", outData);
            end
        end
        if (tmo_flag) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d beats want %0d", rd_idx, exp_q.size());
        end
        stall_seen = outValid && !outReady;
        stall_data = outData;
        stall_last = outLast;
    end

    // ---------------- stimulus ----------------
    task automatic update_fifo();
        fifoEmpty = (fifo_q.size() == 0);
        fifoData  = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    endtask

    task automatic step();
        logic p;
        @(negedge clk);
        p = fifoReadEn;
        @(posedge clk);
        #1;
        if (p && fifo_q.size() > 0) void'(fifo_q.pop_front());
        update_fifo();
    endtask

    task automatic push_word(input logic [31:0] w, input logic pop_at_last);
        exp_t e;
        fifo_q.push_back(w);
        update_fifo();
        for (int k = 0; k < 4; k++) begin
            e.data = w[k*8 +: 8];
            e.last = (k == 3);
            e.pop  = (k == 3) ? pop_at_last : 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_expect(input logic [7:0] d, input logic l, input logic p);
        exp_t e;
        e.data = d;
        e.last = l;
        e.pop  = p;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int n);
        int cnt = 0;
        while (rd_idx != exp_q.size() && cnt < n) begin
            step();
            cnt++;
        end
        if (rd_idx != exp_q.size()) begin
            tmo_flag = 1'b1;
            step();
            tmo_flag = 1'b0;
        end
    endtask

    logic [3:0] bp_pat;

    initial begin
        rstN = 1'b0; flush = 1'b0; outReady = 1'b0;
        update_fifo();
        chk_reset = 1'b1;
        step();
        chk_reset = 1'b0;
        rstN = 1'b1;
        step();

        // single word, pop pulses once then idle
        outReady = 1'b1;
        push_word(32'h44332211, 1'b0);
        chk_pop = 1'b1;
        step();
        chk_pop = 1'b0;
        drain(10);
        chk_nv = 1'b1; chk_nopop = 1'b1;
        step();
        chk_nv = 1'b0; chk_nopop = 1'b0;

        // back-to-back words, second pop on the A3 fire
        push_word(32'hA3A2A1A0, 1'b1);
        push_word(32'hB3B2B1B0, 1'b0);
        drain(15);

        // backpressure 1,0,0,1
        bp_pat = 4'b1001;
        push_word(32'hDDCCBBAA, 1'b0);
        for (int i = 0; i < 16; i++) begin
            outReady = bp_pat[i % 4];
            step();
        end
        outReady = 1'b1;
        drain(10);

        // empty guard with random ready
        chk_nv = 1'b1; chk_nopop = 1'b1;
        for (int i = 0; i < 20; i++) begin
            outReady = 1'($urandom_range(0, 1));
            step();
        end
        chk_nv = 1'b0; chk_nopop = 1'b0;
        outReady = 1'b1;
        push_word(32'h01020304, 1'b0);
        chk_pop = 1'b1;
        step();
        chk_pop = 1'b0;
        chk_v = 1'b1;
        step();
        chk_v = 1'b0;
        drain(10);

        // flush while beat 0x21 fires; next word follows cleanly
        fifo_q.push_back(32'h87654321);
        fifo_q.push_back(32'h0000CAFE);
        update_fifo();
        push_expect(8'h21, 1'b0, 1'b0);
        push_expect(8'hFE, 1'b0, 1'b0);
        push_expect(8'hCA, 1'b0, 1'b0);
        push_expect(8'h00, 1'b0, 1'b0);
        push_expect(8'h00, 1'b1, 1'b0);
        chk_pop = 1'b1;
        step();
        chk_pop = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk_nv = 1'b1; chk_pop = 1'b1;
        step();
        chk_nv = 1'b0; chk_pop = 1'b0;
        drain(10);

        // asynchronous reset while beat 2 is presented
        fifo_q.push_back(32'h0D0C0B0A);
        update_fifo();
        push_expect(8'h0A, 1'b0, 1'b0);
        push_expect(8'h0B, 1'b0, 1'b0);
        step();
        step();
        step();
        rstN = 1'b0;
        fifo_q.delete();
        update_fifo();
        chk_reset = 1'b1;
        step();
        chk_reset = 1'b0;
        rstN = 1'b1;
        step();
        push_word(32'h55667788, 1'b0);
        drain(10);
        chk_nv = 1'b1;
        step();
        chk_nv = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
